spislave_sequencer: RTL and testbench
=====================================

// Module: spislave_sequencer
// PURPOSE
//  SPI mode-0 target (CPOL=0, CPHA=0, MSB first) for a peripheral that is driven by an external SPI master.
//  - Full duplex: per chip-select frame, byte k is sent on miso from buffer[k]; byte k received on mosi overwrites buffer[k].
//  - Host side reads and writes the buffer through port A, then arms the block and collects a completion pulse and byte count.
// PARAMETERS
//  num_bytes  8192               buffer depth in bytes
//  addr_bits  $clog2(num_bytes)  buffer/counter address width (localparam)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          async active-low reset
//  buf_addr     in   addr_bits  host buffer address (port A)
//  buf_wr_val   in   8          host write data
//  buf_rd_val   out  8          host read data, 1-cycle latency
//  buf_wr_en    in   1          host write strobe
//  xfer_enable  in   1          arm: accept the next cs_n frame
//  xfer_length  in   addr_bits  max bytes stored/sent per frame; 0 = none
//  xfer_complete out 1          1-cycle pulse at end of frame
//  xfer_count   out  addr_bits  whole bytes exchanged in last frame (saturates at xfer_length)
//  overrun      out  1          sticky: master clocked more than xfer_length bytes
//  sclk, mosi, cs_n in 1        SPI bus from master (asynchronous to clk)
//  miso         out  1          serial data out
//  miso_oe      out  1          tristate enable for miso pad
// BEHAVIOUR
//  Reset values: miso=1, miso_oe=0, xfer_complete=0, xfer_count=0, overrun=0, state=IDLE.
//  Synchronisation:
//   - sclk, mosi and cs_n each pass through a 2-flop synchroniser; edges are detected on the synchronised copies.
//   - Bus requirements: sclk high/low each >= 6 clk; cs_n fall to first sclk rise >= 6 clk.
//  States:
//   - IDLE: wait for a cs_n falling edge with xfer_enable=1.
//     - On that edge: idx<=0, bit count<=0, clear overrun, go to FETCH.
//     - With xfer_enable=0, cs_n is ignored and miso_oe stays 0.
//   - FETCH: port B addr=idx; on the next cycle tx_shift<=buf[idx], or 8'hFF if idx>=xfer_length.
//     Then go to SHIFT with miso_oe=1.
//   - SHIFT:
//     - On each sclk rise: rx_shift<={rx_shift[6:0],mosi}, bit count++.
//     - On each sclk fall: tx_shift<<1.
//     - miso=tx_shift[7] at all times.
//     - After the 8th rising edge go to STORE.
//   - STORE:
//     - if idx<xfer_length: write rx_shift to buf[idx] (port B), xfer_count<=idx+1.
//     - else overrun<=1 and nothing is written.
//     - idx++ saturating at 2^addr_bits-1; bit count<=0; go to FETCH.
//     - The next MSB is on miso before the following sclk fall.
//   - DONE: entered from any non-IDLE state on a cs_n rise.
//     - 1-cycle xfer_complete pulse; miso_oe<=0; go to IDLE.
//     - A partial byte (bit count 1..7) is discarded, never written, and not counted.
//  Boundaries:
//   - xfer_length=0: every byte clocked sends 0xFF, nothing is stored, xfer_count=0, overrun=1.
//   - Host port A write to the same address as a port B write in the same cycle: port B wins (documented, not guarded).
//   - xfer_enable is sampled only at the cs_n fall; deasserting it mid-frame has no effect.
//   - cs_n rise and sclk edge in the same cycle: cs_n wins.
//   - A cs_n fall while in DONE is missed; the master must hold cs_n high >= 4 clk between frames.
//   - Reset mid-frame: return to IDLE immediately with outputs at reset values. If cs_n is still low after reset,
//     the block waits for cs_n high then low before starting a frame (an armed flag is set only on observed cs_n high).
//  xfer_count and overrun hold their values until the next accepted cs_n fall.
// STRUCTURE
//  Shared package spi_pkg:
//   - SPI state one-hot encodings (IDLE/FETCH/SHIFT/STORE/DONE)
//   - TX_FILL=8'hFF
//   - SYNC_STAGES=2
//  Sub-modules:
//   - existing dual-port spibuf: host on port A, sequencer on port B.
//   - new spi_sync: parameterised N-flop synchroniser plus rise/fall pulse outputs, used for sclk, mosi and cs_n.
//  Bit shifting stays in this module.
// TESTING
//  1. Preload buf[0..3]=A5,3C,FF,00; xfer_length=4; master sends 11,22,33,44
//     -> miso bytes A5,3C,FF,00; buf[0..3]=11,22,33,44; xfer_complete pulses once; xfer_count=4; overrun=0.
//  2. xfer_length=2; master clocks 3 bytes (mosi 01,02,03)
//     -> third miso byte FF; buf[2] unchanged; xfer_count=2; overrun=1.
//  3. cs_n rises after 12 bits
//     -> buf[0] written, buf[1] untouched; xfer_count=1; one xfer_complete pulse; miso_oe=0.
//  4. xfer_enable=0 and a 2-byte frame -> no buffer writes, miso_oe stays 0, no xfer_complete pulse.
//  5. rst_n asserted mid-byte with cs_n still low
//     -> outputs return to reset values; the remaining bits are ignored;
//        the next full frame after a cs_n high/low works as in test 1.
//  6. sclk half-period = 6 clk (minimum), 64-byte frame, random data
//     -> the scoreboard matches every miso and stored byte.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI target sequencer.
// One-hot state encodings, idle fill byte, synchroniser depth.
package spi_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic [7:0] TX_FILL = 8'hFF;

    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_SHIFT = 2;
    localparam int S_STORE = 3;
    localparam int S_DONE  = 4;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_FETCH = 5'b00010;
    localparam logic [4:0] ST_SHIFT = 5'b00100;
    localparam logic [4:0] ST_STORE = 5'b01000;
    localparam logic [4:0] ST_DONE  = 5'b10000;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchroniser with rise/fall pulses on the synchronised copy.
// Ports: clk, rst_n, d (async in); q (sync out), rise, fall (1-clk pulses).
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sr;
    logic         prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= {N{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sr   <= {sr[N-2:0], d};
            prev <= sr[N-1];
        end
    end

    assign q    = sr[N-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spibuf.sv
// Dual-port byte buffer, registered reads on both ports.
// Port A: host. Port B: sequencer. B wins on a same-address write.
module spibuf #(
    parameter int DEPTH = 8192,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    input  logic          a_we,
    output logic [7:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata,
    input  logic          b_we,
    output logic [7:0]    b_rdata
);

    logic [7:0] mem [DEPTH];

    // B is written last so it overrides A at the same address.
    always_ff @(posedge clk) begin
        if (a_we)
            mem[a_addr] <= a_wdata;
        if (b_we)
            mem[b_addr] <= b_wdata;
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/spislave_sequencer.sv
// SPI mode-0 target: full-duplex byte exchange against a host buffer.
// Ports: host buffer (buf_*), control (xfer_*), overrun, SPI bus (sclk/mosi/cs_n/miso/miso_oe).
module spislave_sequencer
    import spi_pkg::*;
#(
    parameter  int num_bytes = 8192,
    localparam int addr_bits = $clog2(num_bytes)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [addr_bits-1:0] buf_addr,
    input  logic [7:0]           buf_wr_val,
    output logic [7:0]           buf_rd_val,
    input  logic                 buf_wr_en,
    input  logic                 xfer_enable,
    input  logic [addr_bits-1:0] xfer_length,
    output logic                 xfer_complete,
    output logic [addr_bits-1:0] xfer_count,
    output logic                 overrun,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs_n,
    output logic                 miso,
    output logic                 miso_oe
);

    logic sclk_q, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic cs_q, cs_rise, cs_fall;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Resets low so a frame already in progress at reset
    // never looks like a fresh cs_n fall.
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_q, mosi_rise, mosi_fall};

    logic [4:0]           state;
    logic [addr_bits-1:0] idx;
    logic [2:0]           bitcnt;
    logic [7:0]           rx_shift;
    logic [7:0]           tx_shift;
    logic                 fetch_rd;
    logic                 armed;
    logic                 in_range;

    logic [7:0]           pb_rdata;
    logic                 pb_we;

    assign in_range = (idx < xfer_length);
    assign pb_we    = state[S_STORE] & in_range;

    spibuf #(.DEPTH(num_bytes), .AW(addr_bits)) u_buf (
        .clk     (clk),
        .a_addr  (buf_addr),
        .a_wdata (buf_wr_val),
        .a_we    (buf_wr_en),
        .a_rdata (buf_rd_val),
        .b_addr  (idx),
        .b_wdata (rx_shift),
        .b_we    (pb_we),
        .b_rdata (pb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            bitcnt     <= '0;
            rx_shift   <= '0;
            tx_shift   <= TX_FILL;
            fetch_rd   <= 1'b0;
            armed      <= 1'b0;
            miso_oe    <= 1'b0;
            overrun    <= 1'b0;
            xfer_count <= '0;
        end else begin
            if (cs_q)
                armed <= 1'b1;
            if (cs_rise && !state[S_IDLE] && !state[S_DONE]) begin
                state <= ST_DONE;
            end else begin
                unique case (1'b1)
                    state[S_IDLE]: begin
                        if (cs_fall && armed && xfer_enable) begin
                            idx        <= '0;
                            bitcnt     <= '0;
                            overrun    <= 1'b0;
                            xfer_count <= '0;
                            fetch_rd   <= 1'b0;
                            state      <= ST_FETCH;
                        end
                    end
                    state[S_FETCH]: begin
                        // First cycle presents idx, second takes read data.
                        if (!fetch_rd) begin
                            fetch_rd <= 1'b1;
                        end else begin
                            fetch_rd <= 1'b0;
                            tx_shift <= in_range ? pb_rdata : TX_FILL;
                            miso_oe  <= 1'b1;
                            state    <= ST_SHIFT;
                        end
                    end
                    state[S_SHIFT]: begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[6:0], mosi_q};
                            bitcnt   <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7)
                                state <= ST_STORE;
                        // The fall that closes the previous byte must
                        // not shift out the freshly loaded MSB.
                        end else if (sclk_fall && bitcnt != 3'd0) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                    state[S_STORE]: begin
                        if (in_range)
                            xfer_count <= idx + 1'b1;
                        else
                            overrun <= 1'b1;
                        if (idx != {addr_bits{1'b1}})
                            idx <= idx + 1'b1;
                        bitcnt <= '0;
                        state  <= ST_FETCH;
                    end
                    state[S_DONE]: begin
                        miso_oe <= 1'b0;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign miso          = tx_shift[7];
    assign xfer_complete = state[S_DONE];

endmodule

// File: tb/tb_spislave_sequencer.sv
// Directed + randomized bench for spislave_sequencer.
// Frame-level reference model of buffer, miso bytes, count and overrun.
module tb_spislave_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] buf_addr = '0;
    logic [7:0]  buf_wr_val = '0;
    logic [7:0]  buf_rd_val;
    logic        buf_wr_en = 1'b0;
    logic        xfer_enable = 1'b0;
    logic [12:0] xfer_length = '0;
    logic        xfer_complete;
    logic [12:0] xfer_count;
    logic        overrun;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic        miso;
    logic        miso_oe;

    spislave_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .buf_addr(buf_addr), .buf_wr_val(buf_wr_val),
        .buf_rd_val(buf_rd_val), .buf_wr_en(buf_wr_en),
        .xfer_enable(xfer_enable), .xfer_length(xfer_length),
        .xfer_complete(xfer_complete), .xfer_count(xfer_count),
        .overrun(overrun), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int oe_cycles = 0;

    always @(posedge clk) begin
        if (xfer_complete === 1'b1) pulses++;
        if (miso_oe === 1'b1) oe_cycles++;
    end

    logic [7:0] model [0:127];
    logic [7:0] mo [0:127];
    logic [7:0] mi [0:127];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_wr(input int a, input logic [7:0] d);
        @(negedge clk);
        buf_addr = 13'(a);
        buf_wr_val = d;
        buf_wr_en = 1'b1;
        @(negedge clk);
        buf_wr_en = 1'b0;
    endtask

    task automatic host_rd(input int a, output logic [7:0] d);
        @(negedge clk);
        buf_addr = 13'(a);
        @(negedge clk);
        d = buf_rd_val;
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) begin
            model[i] = 8'($urandom);
            host_wr(i, model[i]);
        end
    endtask

    task automatic load_model(input int n);
        for (int i = 0; i < n; i++) host_wr(i, model[i]);
    endtask

    task automatic cs_low(input int h);
        @(negedge clk);
        cs_n = 1'b0;
        clk_n(h);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs_n = 1'b1;
        clk_n(8);
    endtask

    // Master drives mosi while sclk is low, samples miso just before rise.
    task automatic bits(input int first, input int n, input int h);
        for (int b = first; b < first + n; b++) begin
            mosi = mo[b / 8][7 - (b % 8)];
            clk_n(h);
            mi[b / 8][7 - (b % 8)] = miso;
            sclk = 1'b1;
            clk_n(h);
            sclk = 1'b0;
        end
    endtask

    task automatic readback(input string tag, input int p);
        logic [7:0] d;
        for (int i = 0; i < p; i++) begin
            host_rd(i, d);
            chk($sformatf("%s_buf%0d", tag, i), 32'(d), 32'(model[i]));
        end
    endtask

    // Compare a finished frame against the model, then fold it in.
    task automatic frame_check(input string tag, input int len,
                               input int nbits, input int p);
        int nfull;
        int ncnt;
        logic [7:0] e;
        nfull = nbits / 8;
        ncnt = (nfull < len) ? nfull : len;
        for (int k = 0; k < nfull; k++) begin
            e = (k < len) ? model[k] : 8'hFF;
            chk($sformatf("%s_miso%0d", tag, k), 32'(mi[k]), 32'(e));
        end
        for (int k = 0; k < ncnt; k++) model[k] = mo[k];
        chk({tag, "_count"}, 32'(xfer_count), 32'(ncnt));
        chk({tag, "_ovr"}, 32'(overrun), 32'(nfull > len));
        chk({tag, "_oe"}, 32'(miso_oe), 32'd0);
        readback(tag, p);
    endtask

    int p0;
    int oe0;

    initial begin
        clk_n(3);
        rst_n = 1'b1;
        clk_n(3);
        chk("rst_miso", 32'(miso), 32'd1);
        chk("rst_oe", 32'(miso_oe), 32'd0);
        chk("rst_cmp", 32'(xfer_complete), 32'd0);
        chk("rst_cnt", 32'(xfer_count), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);

        // 1: basic 4-byte exchange
        xfer_enable = 1'b1;
        xfer_length = 13'd4;
        model[0] = 8'hA5; model[1] = 8'h3C;
        model[2] = 8'hFF; model[3] = 8'h00;
        model[4] = 8'($urandom);
        load_model(5);
        mo[0] = 8'h11; mo[1] = 8'h22; mo[2] = 8'h33; mo[3] = 8'h44;
        p0 = pulses; oe0 = oe_cycles;
        cs_low(8);
        bits(0, 32, 8);
        cs_high();
        chk("t1_pulse", 32'(pulses - p0), 32'd1);
        chk("t1_oe_seen", 32'(oe_cycles > oe0), 32'd1);
        frame_check("t1", 4, 32, 5);

        // 2: overrun, enable dropped mid-frame
        xfer_length = 13'd2;
        load_rand(4);
        for (int k = 0; k < 3; k++) mo[k] = 8'(k + 1);
        p0 = pulses;
        cs_low(8);
        xfer_enable = 1'b0;
        bits(0, 24, 8);
        cs_high();
        xfer_enable = 1'b1;
        chk("t2_pulse", 32'(pulses - p0), 32'd1);
        frame_check("t2", 2, 24, 4);

        // 3: partial trailing byte discarded
        xfer_length = 13'd4;
        load_rand(4);
        mo[0] = 8'($urandom); mo[1] = 8'($urandom);
        p0 = pulses;
        cs_low(8);
        bits(0, 12, 8);
        cs_high();
        chk("t3_pulse", 32'(pulses - p0), 32'd1);
        frame_check("t3", 4, 12, 4);

        // 4: not armed -> frame ignored
        xfer_enable = 1'b0;
        load_rand(4);
        mo[0] = 8'($urandom); mo[1] = 8'($urandom);
        p0 = pulses; oe0 = oe_cycles;
        cs_low(8);
        bits(0, 16, 8);
        cs_high();
        chk("t4_pulse", 32'(pulses - p0), 32'd0);
        chk("t4_oe", 32'(oe_cycles - oe0), 32'd0);
        chk("t4_cnt", 32'(xfer_count), 32'd1);
        readback("t4", 4);
        xfer_enable = 1'b1;

        // 5: reset mid-byte with cs_n low
        load_rand(4);
        for (int k = 0; k < 4; k++) mo[k] = 8'($urandom);
        cs_low(8);
        bits(0, 12, 8);
        @(negedge clk);
        rst_n = 1'b0;
        clk_n(2);
        chk("t5_miso", 32'(miso), 32'd1);
        chk("t5_oe", 32'(miso_oe), 32'd0);
        chk("t5_cmp", 32'(xfer_complete), 32'd0);
        chk("t5_cnt", 32'(xfer_count), 32'd0);
        chk("t5_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        p0 = pulses; oe0 = oe_cycles;
        bits(12, 20, 8);
        cs_high();
        chk("t5_pulse", 32'(pulses - p0), 32'd0);
        chk("t5_oe_idle", 32'(oe_cycles - oe0), 32'd0);
        chk("t5_cnt2", 32'(xfer_count), 32'd0);
        model[0] = mo[0];
        readback("t5a", 4);
        model[0] = 8'hA5; model[1] = 8'h3C;
        model[2] = 8'hFF; model[3] = 8'h00;
        load_model(4);
        mo[0] = 8'h11; mo[1] = 8'h22; mo[2] = 8'h33; mo[3] = 8'h44;
        p0 = pulses;
        cs_low(8);
        bits(0, 32, 8);
        cs_high();
        chk("t5_pulse2", 32'(pulses - p0), 32'd1);
        frame_check("t5b", 4, 32, 4);

        // 6: minimum sclk timing, 64 random bytes
        xfer_length = 13'd64;
        load_rand(65);
        for (int k = 0; k < 64; k++) mo[k] = 8'($urandom);
        p0 = pulses;
        cs_low(6);
        bits(0, 512, 6);
        cs_high();
        chk("t6_pulse", 32'(pulses - p0), 32'd1);
        frame_check("t6", 64, 512, 65);

        // 7: zero length -> all fill, nothing stored
        xfer_length = 13'd0;
        load_rand(2);
        mo[0] = 8'($urandom); mo[1] = 8'($urandom);
        cs_low(8);
        bits(0, 16, 8);
        cs_high();
        frame_check("t7", 0, 16, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
